// File: rtl/ram512_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram512_req_ctrl_pkg
// Brief  : Shared op codes, FSM states and RAM geometry for the RAM512 front end.
// Rev    : 1.0  initial release
// ============================================================================
package ram512_req_ctrl_pkg;

  localparam int c_ram_depth = 512;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_FILL = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

endpackage : ram512_req_ctrl_pkg
`default_nettype wire

// File: rtl/ram512_req_ctrl_ram.sv
`default_nettype none
// ============================================================================
// Module : ram512_req_ctrl_ram
// Brief  : RAM512 word store; combinational read on address, write on clk edge.
// Rev    : 1.0  initial release
// ============================================================================
module ram512_req_ctrl_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // No reset: contents survive controller resets.
  always_ff @(posedge clk) begin
    if (load) begin
      r_mem[address] <= data_in;
    end
  end

  assign data_out = r_mem[address];

endmodule : ram512_req_ctrl_ram
`default_nettype wire

// File: rtl/ram512_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ram512_req_ctrl
// Brief  : valid/ready command front end (read/write/fill) driving RAM512,
//          with a 1-entry registered read response.
// Rev    : 1.0  initial release
// ============================================================================
module ram512_req_ctrl
  import ram512_req_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 9,
  parameter bit FILL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              fill_done
);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_next;
  logic [ADDR_W:0]   w_cnt_inc;
  logic [DATA_W-1:0] r_fill_val;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_fill_done;
  logic              w_fill_last;
  logic              w_accept;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_fill_acc;
  logic              w_ram_load;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_in;
  logic [DATA_W-1:0] w_ram_out;
  op_e               w_op;

  assign w_op       = op_e'(req_op);
  assign req_ready  = (r_state == ST_IDLE) && (!r_rsp_valid || rsp_ready);
  assign w_accept   = req_valid && req_ready;
  assign w_rd_acc   = w_accept && (w_op == OP_RD);
  assign w_wr_acc   = w_accept && (w_op == OP_WR);
  assign w_fill_acc = w_accept && (w_op == OP_FILL) && FILL_EN;
  assign w_cnt_inc  = r_cnt + {{ADDR_W{1'b0}}, 1'b1};

  // The extra counter bit flags the step past the last word.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fill_last  = 1'b0;
    w_ram_load   = 1'b0;
    w_ram_addr   = req_addr;
    w_ram_in     = req_data;
    case (r_state)
      ST_IDLE: begin
        w_ram_load = w_wr_acc;
        if (w_fill_acc) begin
          w_state_next = ST_FILL;
          w_cnt_next   = '0;
        end
      end
      ST_FILL: begin
        w_ram_load = 1'b1;
        w_ram_addr = r_cnt[ADDR_W-1:0];
        w_ram_in   = r_fill_val;
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc[ADDR_W]) begin
          w_fill_last  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_fill_val  <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_fill_done <= w_fill_last;
      if (w_fill_acc) begin
        r_fill_val <= req_data;
      end
    end
  end

  // A read accepted while the old response drains keeps rsp_valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_rd_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_ram_out;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  ram512_req_ctrl_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (clk),
    .load     (w_ram_load),
    .address  (w_ram_addr),
    .data_in  (w_ram_in),
    .data_out (w_ram_out)
  );

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state == ST_FILL);
  assign fill_done = r_fill_done;

endmodule : ram512_req_ctrl
`default_nettype wire

// File: tb/tb_ram512_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ram512_req_ctrl
// Brief  : Randomized + directed bench for ram512_req_ctrl against a word-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram512_req_ctrl;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [8:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready, rsp_valid, busy, fill_done;
  logic [15:0] rsp_data;
  logic        req_ready0, rsp_valid0, busy0, fill_done0;
  logic [15:0] rsp_data0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram512_req_ctrl #(.DATA_W(16), .ADDR_W(9), .FILL_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .fill_done(fill_done)
  );

  ram512_req_ctrl #(.DATA_W(16), .ADDR_W(9), .FILL_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
    .busy(busy0), .fill_done(fill_done0)
  );

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // Word-level model: memory array, pending response, remaining fill writes.
  logic [15:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_rv;
  logic [15:0] m_rd;
  bit          m_rk;
  int          m_left;
  bit          m_done;
  logic [15:0] m_fv;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rv   <= 1'b0;
      m_rd   <= '0;
      m_rk   <= 1'b1;
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (rsp_ready) m_rv <= 1'b0;
      if (m_left > 0) begin
        m_mem[DEPTH - m_left]   <= m_fv;
        m_known[DEPTH - m_left] <= 1'b1;
        m_left <= m_left - 1;
      end else if (req_valid && (!m_rv || rsp_ready)) begin
        case (req_op)
          2'b00: begin
            m_rv <= 1'b1;
            m_rd <= m_mem[req_addr];
            m_rk <= m_known[req_addr];
          end
          2'b01: begin
            m_mem[req_addr]   <= req_data;
            m_known[req_addr] <= 1'b1;
          end
          2'b10: begin
            m_left <= DEPTH;
            m_fv   <= req_data;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check(req_ready === ((m_left == 0) && (!m_rv || rsp_ready)), "req_ready",
          32'(req_ready), 32'((m_left == 0) && (!m_rv || rsp_ready)));
    check(rsp_valid === m_rv, "rsp_valid", 32'(rsp_valid), 32'(m_rv));
    check(busy === (m_left > 0), "busy", 32'(busy), 32'(m_left > 0));
    check(fill_done === m_done, "fill_done", 32'(fill_done), 32'(m_done));
    if (m_rk) check(rsp_data === m_rd, "rsp_data", 32'(rsp_data), 32'(m_rd));
    check(busy0 === 1'b0, "nofill_busy", 32'(busy0), 32'd0);
    check(fill_done0 === 1'b0, "nofill_done", 32'(fill_done0), 32'd0);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_req(input logic [1:0] op, input logic [8:0] a, input logic [15:0] d);
    bit acc = 1'b0;
    int n = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc) check(1'b0, "accept_timeout", 32'(n), 32'd1000);
  endtask

  task automatic read_chk(input logic [8:0] a, input logic [15:0] exp, input string name);
    do_req(2'b00, a, 16'h0);
    check(rsp_valid === 1'b1, {name, "_valid"}, 32'(rsp_valid), 32'd1);
    check(rsp_data === exp, name, 32'(rsp_data), 32'(exp));
  endtask

  task automatic wait_fill_end();
    int n = 0;
    while (busy && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check(1'b0, "fill_timeout", 32'(n), 32'd600);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int r;

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check(rsp_valid === 1'b0, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check(rsp_data === 16'h0, "rst_rsp_data", 32'(rsp_data), 32'd0);
    check(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
    check(req_ready === 1'b1, "rst_req_ready", 32'(req_ready), 32'd1);

    // Write then immediate read-back at the top address
    do_req(2'b01, 9'h1FF, 16'hBEEF);
    read_chk(9'h1FF, 16'hBEEF, "wr_rd_1ff");

    // Reads stall behind an unconsumed response, then drain one per cycle
    do_req(2'b01, 9'd10, 16'h1111);
    do_req(2'b01, 9'd11, 16'h2222);
    do_req(2'b01, 9'd12, 16'h3333);
    rsp_ready = 1'b0;
    read_chk(9'd10, 16'h1111, "stall_rd10");
    req_valid = 1'b1; req_op = 2'b00; req_addr = 9'd11;
    repeat (3) begin
      @(negedge clk);
      check(req_ready === 1'b0, "stall_ready", 32'(req_ready), 32'd0);
      check(rsp_data === 16'h1111, "stall_hold", 32'(rsp_data), 32'h1111);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    read_chk(9'd11, 16'h2222, "drain_rd11");
    read_chk(9'd12, 16'h3333, "drain_rd12");

    // Full fill
    do_req(2'b10, 9'd0, 16'hA5A5);
    busy_cnt = 0; done_cnt = 0;
    repeat (520) begin
      @(negedge clk);
      busy_cnt += int'(busy);
      done_cnt += int'(fill_done);
    end
    check(busy_cnt == 512, "fill_busy_cycles", 32'(busy_cnt), 32'd512);
    check(done_cnt == 1, "fill_done_pulses", 32'(done_cnt), 32'd1);
    @(posedge clk); #1;
    read_chk(9'd0, 16'hA5A5, "fill_rd0");
    read_chk(9'd255, 16'hA5A5, "fill_rd255");
    read_chk(9'd511, 16'hA5A5, "fill_rd511");

    // Fill aborted by reset after 100 writes (addresses 0..99)
    do_req(2'b01, 9'd100, 16'h5555);
    do_req(2'b10, 9'd0, 16'h1234);
    repeat (100) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check(busy === 1'b0, "abort_busy", 32'(busy), 32'd0);
    check(rsp_valid === 1'b0, "abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check(rsp_data === 16'h0, "abort_rsp_data", 32'(rsp_data), 32'd0);
    check(fill_done === 1'b0, "abort_fill_done", 32'(fill_done), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    check(req_ready === 1'b1, "abort_req_ready", 32'(req_ready), 32'd1);
    read_chk(9'd99, 16'h1234, "abort_rd99");
    read_chk(9'd100, 16'h5555, "abort_rd100");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 399));
      req_valid = ($urandom_range(0, 1) == 1);
      req_op    = (r < 180) ? 2'b00 : (r < 385) ? 2'b01 : (r < 398) ? 2'b11 : 2'b10;
      req_addr  = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 31));
      req_data  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_fill_end();
    @(posedge clk); #1;

    // Reserved op and fill on the FILL_EN=0 instance leave RAM untouched
    do_req(2'b01, 9'd5, 16'h0077);
    read_chk(9'd5, 16'h0077, "nop_pre_rd5");
    do_req(2'b11, 9'd5, 16'h9999);
    check(rsp_valid === 1'b0, "nop_no_rsp", 32'(rsp_valid), 32'd0);
    check(rsp_valid0 === 1'b0, "nofill_nop_no_rsp", 32'(rsp_valid0), 32'd0);
    read_chk(9'd5, 16'h0077, "nop_rd5");
    do_req(2'b10, 9'd0, 16'hF0F0);
    check(rsp_valid0 === 1'b0, "nofill_no_rsp", 32'(rsp_valid0), 32'd0);
    wait_fill_end();
    read_chk(9'd5, 16'hF0F0, "refill_rd5");
    check(rsp_valid0 === 1'b1, "nofill_rd5_valid", 32'(rsp_valid0), 32'd1);
    check(rsp_data0 === 16'h0077, "nofill_rd5", 32'(rsp_data0), 32'h0077);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_ram512_req_ctrl
`default_nettype wire
